cache_arbiter: RTL and testbench
================================

// Module: cache_arbiter
// PURPOSE
//   Registered two-master arbiter in front of cache_control. Merges the CPU instruction
//   bus (i_*) and data bus (d_*) onto the single cache port (m_*), replacing the
//   combinational imem/dmem mux in the SoC top. Data has priority over instruction,
//   with a starvation bound. One request is outstanding at a time.
// PARAMETERS
//   ADDR_W      32  address width on all three ports
//   DATA_W      32  data width; wmask width is DATA_W/8
//   STARVE_MAX  4   consecutive d grants allowed while i_valid waits; next grant goes to i
// PORTS
//   clk      in   1         system clock; all state on rising edge
//   rstn     in   1         asynchronous active-low reset
//   i_valid  in   1         instruction request; held with i_addr until i_ready
//   i_ready  out  1         one-cycle completion pulse; i_rdata valid same cycle
//   i_addr   in   ADDR_W    instruction address
//   i_rdata  out  DATA_W    instruction read data
//   d_valid  in   1         data request; held with addr/wmask/wdata until d_ready
//   d_ready  out  1         one-cycle completion pulse; d_rdata valid same cycle
//   d_addr   in   ADDR_W    data address
//   d_wmask  in   DATA_W/8  byte write enables; 0 = read
//   d_wdata  in   DATA_W    write data
//   d_rdata  out  DATA_W    data read data
//   m_valid  out  1         request to cache, registered
//   m_ready  in   1         cache completion pulse
//   m_addr   out  ADDR_W    registered request address
//   m_wmask  out  DATA_W/8  registered byte enables (0 for i grants)
//   m_wdata  out  DATA_W    registered write data (0 for i grants)
//   m_rdata  in   DATA_W    cache read data, valid when m_ready=1
//   grant    out  2         {d_owner, i_owner}; 2'b00 when idle (debug/perf)
// BEHAVIOUR
//   Reset (rstn=0, async): state=IDLE, starve_cnt=0, m_valid=0, m_addr/m_wmask/m_wdata=0,
//     grant=0; i_ready/d_ready=0 and i_rdata/d_rdata=0 (because grant=0).
//     An in-flight cache transaction is abandoned. cache_control shares rstn.
//   FSM states: IDLE, BUSY_I, BUSY_D.
//   IDLE: if d_valid and (!i_valid or starve_cnt<STARVE_MAX), go to BUSY_D.
//     Else if i_valid, go to BUSY_I. Else stay in IDLE.
//     On the grant edge, latch the winner's addr, wmask and wdata into m_*.
//     For BUSY_I, m_wmask and m_wdata are forced to 0. Set m_valid=1.
//   starve_cnt (on the grant edge):
//     d grant with i_valid=1: increment, saturating at STARVE_MAX.
//     d grant with i_valid=0, or any i grant: clear to 0.
//   BUSY_x: m_valid and m_* are held stable. Owner inputs are ignored (already latched).
//     The other master waits with no ready.
//   Completion (BUSY_x and m_ready=1), all combinational in the same cycle:
//     x_ready = m_ready & x_valid; x_rdata = m_rdata.
//     Non-owner ready=0 and rdata=0.
//   Completion edge: state goes to IDLE and m_valid=0.
//     m_addr/m_wmask/m_wdata keep their last values. grant=0 in IDLE.
//   Latency: valid seen in IDLE at cycle N gives m_valid at N+1.
//     m_ready at cycle M>=N+1 gives x_ready at M.
//     A valid still high at M+1 is a new request. Minimum 2 cycles per transfer.
//   Owner drops valid mid-transaction (protocol violation):
//     the cache transaction still completes and the FSM returns to IDLE.
//     No ready pulse is issued, because x_ready is gated by x_valid.
//   m_ready in IDLE is ignored.
//   Both valids arriving in the same IDLE cycle: resolved by the priority rule above.
//   grant is one-hot in BUSY: BUSY_I=2'b01, BUSY_D=2'b10.
// TESTING
//   1. Hold rstn=0 and drive all valids=1 with m_ready=1. Expect m_valid=0, grant=0,
//      and no ready pulses. Release rstn: first grant goes to d.
//   2. Lone i_valid with i_addr=0x100. Expect m_valid=1 and m_addr=0x100 with
//      m_wmask=0 on the next cycle. m_ready after 3 cycles with m_rdata=0xDEADBEEF
//      -> i_ready=1 and i_rdata=0xDEADBEEF in that cycle; d_ready=0.
//   3. Simultaneous i_valid/d_valid, d write with wmask=4'b0011 and wdata=0x1234 at
//      0x200. Expect d granted first with m_wmask=0011 and m_wdata=0x1234;
//      i granted after d_ready.
//   4. d_valid held continuously, i_valid waiting, STARVE_MAX=4. Expect exactly
//      4 d grants, then 1 i grant, then d again; starve_cnt returns to 0.
//   5. Assert rstn=0 while BUSY_D with m_valid=1. Expect m_valid=0 and grant=0
//      immediately, without waiting for clk; no d_ready ever for that request.
//   6. Owner drops d_valid in BUSY_D before m_ready. Expect no d_ready, FSM in IDLE
//      after m_ready, and a pending i_valid granted next.

Source files
------------

// File: rtl/cache_arbiter.sv
// Registered two-master arbiter that merges the CPU instruction and data buses onto the single
// cache port. Data has priority, bounded by a starvation counter; one request in flight at a time.
module cache_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rstn,

    input  logic                i_valid,
    output logic                i_ready,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,

    input  logic                d_valid,
    output logic                d_ready,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W/8-1:0] d_wmask,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                m_valid,
    input  logic                m_ready,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W/8-1:0] m_wmask,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W-1:0]   m_rdata,

    output logic [1:0]          grant
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_nxt;
    logic             grant_i;
    logic             grant_d;
    logic             done;

    // NOTE: every signal written here gets a default first, so no path can leave one unassigned
    // and infer a latch.
    always_comb begin
        next_state = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (d_valid && (!i_valid || (starve_cnt < CNT_MAX))) begin
                    next_state = BUSY_D;
                    grant_d    = 1'b1;
                end else if (i_valid) begin
                    next_state = BUSY_I;
                    grant_i    = 1'b1;
                end
            end
            BUSY_I, BUSY_D: begin
                if (m_ready) begin
                    next_state = IDLE;
                    done       = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The count only moves on a grant edge; it saturates so a long d burst cannot wrap it.
    always_comb begin
        starve_nxt = starve_cnt;
        if (grant_d) begin
            if (!i_valid)
                starve_nxt = '0;
            else if (starve_cnt != CNT_MAX)
                starve_nxt = starve_cnt + 1'b1;
        end else if (grant_i) begin
            starve_nxt = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= next_state;
            starve_cnt <= starve_nxt;
        end
    end

    // The request is captured once at grant time and held until completion, so the owner's
    // inputs are free to change while the cache works.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_valid <= 1'b0;
            m_addr  <= '0;
            m_wmask <= '0;
            m_wdata <= '0;
        end else if (grant_d) begin
            m_valid <= 1'b1;
            m_addr  <= d_addr;
            m_wmask <= d_wmask;
            m_wdata <= d_wdata;
        end else if (grant_i) begin
            m_valid <= 1'b1;
            m_addr  <= i_addr;
            m_wmask <= '0;
            m_wdata <= '0;
        end else if (done) begin
            m_valid <= 1'b0;
        end
    end

    assign grant = {state == BUSY_D, state == BUSY_I};

    // Ready is gated by the owner's valid, so an owner that abandons its request gets no pulse.
    assign i_ready = (state == BUSY_I) && m_ready && i_valid;
    assign d_ready = (state == BUSY_D) && m_ready && d_valid;
    assign i_rdata = ((state == BUSY_I) && m_ready) ? m_rdata : '0;
    assign d_rdata = ((state == BUSY_D) && m_ready) ? m_rdata : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: directed stimulus pushes expected grants and completions,
// an independent monitor pops and compares them whenever the DUT presents a grant or a ready.
module tb_cache_arbiter;

    typedef struct {
        logic [1:0]  grant;
        logic [31:0] addr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } grant_t;

    logic        clk;
    logic        rstn;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_addr;
    logic [3:0]  d_wmask;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_addr;
    logic [3:0]  m_wmask;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic [1:0]  grant;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          resp_delay = 1;
    bit          force_ready = 1'b0;
    grant_t      exp_grant[$];
    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];

    cache_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .d_addr  (d_addr),
        .d_wmask (d_wmask),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_addr  (m_addr),
        .m_wmask (m_wmask),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .grant   (grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] cache_data(input logic [31:0] addr);
        return (addr == 32'h100) ? 32'hDEAD_BEEF : (addr ^ 32'h5A5A_0000);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_grant(input logic [1:0] g, input logic [31:0] a,
                              input logic [3:0] wm, input logic [31:0] wd);
        grant_t e;
        e.grant = g;
        e.addr  = a;
        e.wmask = wm;
        e.wdata = wd;
        exp_grant.push_back(e);
    endtask

    // Cache model: answers a held m_valid after resp_delay cycles.
    initial begin
        int cnt;
        cnt     = 0;
        m_ready = 1'b0;
        m_rdata = 32'h0BAD_0BAD;
        forever begin
            @(negedge clk);
            if (force_ready) begin
                m_ready = 1'b1;
                m_rdata = 32'hFFFF_FFFF;
                cnt     = 0;
            end else if (!rstn || !m_valid || m_ready) begin
                m_ready = 1'b0;
                m_rdata = 32'h0BAD_0BAD;
                cnt     = 0;
            end else begin
                cnt++;
                if (cnt >= resp_delay) begin
                    m_ready = 1'b1;
                    m_rdata = cache_data(m_addr);
                end
            end
        end
    end

    // Monitor: compares every new grant and every ready pulse against the scoreboard.
    initial begin
        logic   prev_mv;
        grant_t e;
        logic [31:0] d;
        prev_mv = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (m_valid && !prev_mv) begin
                if (exp_grant.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_grant: got grant %0h addr %0h expected none", grant, m_addr);
                end else begin
                    e = exp_grant.pop_front();
                    check("grant", grant, e.grant);
                    check("m_addr", m_addr, e.addr);
                    check("m_wmask", m_wmask, e.wmask);
                    check("m_wdata", m_wdata, e.wdata);
                end
            end
            prev_mv = m_valid;
            if (i_ready) begin
                check("i_ready_excl_d", d_ready, 0);
                check("d_rdata_idle", d_rdata, 0);
                if (exp_i.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_i_ready: got i_rdata %0h expected no pulse", i_rdata);
                end else begin
                    d = exp_i.pop_front();
                    check("i_rdata", i_rdata, d);
                end
            end
            if (d_ready) begin
                check("d_ready_excl_i", i_ready, 0);
                check("i_rdata_idle", i_rdata, 0);
                if (exp_d.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_d_ready: got d_rdata %0h expected no pulse", d_rdata);
                end else begin
                    d = exp_d.pop_front();
                    check("d_rdata", d_rdata, d);
                end
            end
        end
    end

    task automatic i_req(input logic [31:0] addr, output int cycles);
        @(negedge clk);
        i_valid = 1'b1;
        i_addr  = addr;
        cycles  = -1;
        for (int n = 0; n < 200; n++) begin
            #3;
            if (i_ready) begin
                cycles = n;
                break;
            end
            @(negedge clk);
        end
        if (cycles < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL i_timeout: got no i_ready for addr %0h expected a pulse", addr);
        end
    endtask

    task automatic d_req(input logic [31:0] addr, input logic [3:0] wm, input logic [31:0] wd,
                         output int cycles);
        @(negedge clk);
        d_valid = 1'b1;
        d_addr  = addr;
        d_wmask = wm;
        d_wdata = wd;
        cycles  = -1;
        for (int n = 0; n < 200; n++) begin
            #3;
            if (d_ready) begin
                cycles = n;
                break;
            end
            @(negedge clk);
        end
        if (cycles < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL d_timeout: got no d_ready for addr %0h expected a pulse", addr);
        end
    endtask

    task automatic i_stop();
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic d_stop();
        @(negedge clk);
        d_valid = 1'b0;
    endtask

    initial begin
        int c;
        int c2;
        rstn    = 1'b0;
        i_valid = 1'b0;
        i_addr  = '0;
        d_valid = 1'b0;
        d_addr  = '0;
        d_wmask = '0;
        d_wdata = '0;

        // 1: reset holds everything quiet even with all valids and m_ready high.
        force_ready = 1'b1;
        i_valid     = 1'b1;
        i_addr      = 32'h40;
        d_valid     = 1'b1;
        d_addr      = 32'h80;
        repeat (3) begin
            @(negedge clk);
            #3;
            check("rst_m_valid", m_valid, 0);
            check("rst_grant", grant, 0);
            check("rst_i_ready", i_ready, 0);
            check("rst_d_ready", d_ready, 0);
            check("rst_rdata", {i_rdata, d_rdata}, 0);
            check("rst_m_addr", m_addr, 0);
        end
        push_grant(2'b10, 32'h80, 4'h0, 32'h0);
        push_grant(2'b01, 32'h40, 4'h0, 32'h0);
        exp_d.push_back(cache_data(32'h80));
        exp_i.push_back(cache_data(32'h40));
        @(negedge clk);
        force_ready = 1'b0;
        rstn        = 1'b1;
        fork
            begin d_req(32'h80, 4'h0, 32'h0, c); d_stop(); end
            begin i_req(32'h40, c2); i_stop(); end
        join

        // 2: lone instruction fetch, cache answers after 3 cycles.
        resp_delay = 3;
        push_grant(2'b01, 32'h100, 4'h0, 32'h0);
        exp_i.push_back(32'hDEAD_BEEF);
        i_req(32'h100, c);
        check("i_latency", c, 3);
        i_stop();

        // 3: simultaneous requests, data write wins first.
        resp_delay = 2;
        push_grant(2'b10, 32'h200, 4'b0011, 32'h1234);
        push_grant(2'b01, 32'h300, 4'h0, 32'h0);
        exp_d.push_back(cache_data(32'h200));
        exp_i.push_back(cache_data(32'h300));
        fork
            begin d_req(32'h200, 4'b0011, 32'h1234, c); d_stop(); end
            begin i_req(32'h300, c2); i_stop(); end
        join

        // 4: continuous data traffic; i gets in after exactly four d grants.
        resp_delay = 1;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) push_grant(2'b01, 32'h2000, 4'h0, 32'h0);
            push_grant(2'b10, 32'h1000 + 32'(4 * k), 4'h0, 32'h0);
            exp_d.push_back(cache_data(32'h1000 + 32'(4 * k)));
        end
        exp_i.push_back(cache_data(32'h2000));
        fork
            begin
                for (int k = 0; k < 6; k++) d_req(32'h1000 + 32'(4 * k), 4'h0, 32'h0, c);
                d_stop();
            end
            begin i_req(32'h2000, c2); i_stop(); end
        join
        @(negedge clk);
        check("starve_cnt_cleared", dut.starve_cnt, 0);

        // 5: asynchronous reset in the middle of a data transaction.
        resp_delay = 20;
        push_grant(2'b10, 32'h500, 4'hF, 32'hCAFE);
        @(negedge clk);
        d_valid = 1'b1;
        d_addr  = 32'h500;
        d_wmask = 4'hF;
        d_wdata = 32'hCAFE;
        @(negedge clk);
        #3;
        check("busy_m_valid", m_valid, 1);
        rstn = 1'b0;
        #1;
        check("async_m_valid", m_valid, 0);
        check("async_grant", grant, 0);
        check("async_d_ready", d_ready, 0);
        d_valid = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // 6: data owner abandons its request; i is served next, no d_ready.
        resp_delay = 4;
        push_grant(2'b10, 32'h600, 4'h0, 32'h0);
        push_grant(2'b01, 32'h700, 4'h0, 32'h0);
        exp_i.push_back(cache_data(32'h700));
        fork
            begin
                @(negedge clk);
                d_valid = 1'b1;
                d_addr  = 32'h600;
                d_wmask = 4'h0;
                d_wdata = 32'h0;
                repeat (2) @(negedge clk);
                d_valid = 1'b0;
            end
            begin
                repeat (2) @(negedge clk);
                i_req(32'h700, c2);
                i_stop();
            end
        join

        repeat (5) @(negedge clk);
        #3;
        check("idle_grant", grant, 0);
        check("grant_q_empty", exp_grant.size(), 0);
        check("i_q_empty", exp_i.size(), 0);
        check("d_q_empty", exp_d.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
